// File: rtl/inst_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_mem_loader                                                            |
// | Frames a length-prefixed, XOR-checksummed UART image into big-endian words |
// | and writes them to instruction RAM while holding the CPU in reset.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_mem_loader #(
   parameter int unsigned ROM_SIZE       = 256,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error,
   output logic [1:0]  err_code,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   localparam logic [31:0] c_rom_size     = 32'(ROM_SIZE);
   localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  c_err_len      = 2'd1;
   localparam logic [1:0]  c_err_chk      = 2'd2;
   localparam logic [1:0]  c_err_timeout  = 2'd3;

   state_t      r_state, w_next_state;
   logic [15:0] r_len;
   logic [7:0]  r_chk;
   logic [1:0]  r_byte_cnt;
   logic [23:0] r_shift;
   logic [31:0] r_timer;
   logic        r_wr_en, r_cpu_hold, r_load_done, r_load_error;
   logic [31:0] r_wr_addr, r_wr_data;
   logic [1:0]  r_err_code;
   logic [15:0] r_words_loaded;

   logic        w_open, w_accept, w_word_done, w_set_done, w_set_err;
   logic [1:0]  w_err_val;
   logic [15:0] w_len_rx;
   logic        w_len_bad;

   assign w_open    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA)   || (r_state == S_CHECK);
   assign w_len_rx  = {r_len[15:8], rx_data};
   assign w_len_bad = (w_len_rx == 16'd0) || ({16'd0, w_len_rx} > c_rom_size);

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_word_done  = 1'b0;
      w_set_done   = 1'b0;
      w_set_err    = 1'b0;
      w_err_val    = 2'd0;
      case (r_state)
         S_LEN_HI: if (rx_valid) begin
            w_accept     = 1'b1;
            w_next_state = S_LEN_LO;
         end
         S_LEN_LO: if (rx_valid) begin
            w_accept = 1'b1;
            if (w_len_bad) begin
               w_next_state = S_ERROR;
               w_set_err    = 1'b1;
               w_err_val    = c_err_len;
            end else begin
               w_next_state = S_DATA;
            end
         end
         S_DATA: if (rx_valid) begin
            w_accept = 1'b1;
            if (r_byte_cnt == 2'd3) begin
               w_word_done = 1'b1;
               if ((r_words_loaded + 16'd1) == r_len) w_next_state = S_CHECK;
            end
         end
         S_CHECK: if (rx_valid) begin
            w_accept = 1'b1;
            if (rx_data == r_chk) begin
               w_next_state = S_DONE;
               w_set_done   = 1'b1;
            end else begin
               w_next_state = S_ERROR;
               w_set_err    = 1'b1;
               w_err_val    = c_err_chk;
            end
         end
         default: ;
      endcase
      // An open frame with no byte this cycle may expire.
      if (w_open && !rx_valid && (r_timer == c_timeout_last)) begin
         w_next_state = S_ERROR;
         w_set_err    = 1'b1;
         w_err_val    = c_err_timeout;
      end
      // A start pulse overrides everything, including a coincident byte.
      if (load_start) begin
         w_next_state = S_LEN_HI;
         w_accept     = 1'b0;
         w_word_done  = 1'b0;
         w_set_done   = 1'b0;
         w_set_err    = 1'b0;
         w_err_val    = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_len          <= 16'd0;
         r_chk          <= 8'd0;
         r_byte_cnt     <= 2'd0;
         r_shift        <= 24'd0;
         r_timer        <= 32'd0;
         r_wr_en        <= 1'b0;
         r_wr_addr      <= BASE_ADDR;
         r_wr_data      <= 32'd0;
         r_cpu_hold     <= 1'b0;
         r_load_done    <= 1'b0;
         r_load_error   <= 1'b0;
         r_err_code     <= 2'd0;
         r_words_loaded <= 16'd0;
      end else begin
         r_state    <= w_next_state;
         r_wr_en    <= w_word_done;
         r_cpu_hold <= !((w_next_state == S_IDLE) || (w_next_state == S_DONE));
         if (load_start) begin
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_err_code     <= 2'd0;
            r_words_loaded <= 16'd0;
            r_chk          <= 8'd0;
            r_byte_cnt     <= 2'd0;
            r_timer        <= 32'd0;
         end else begin
            if (w_accept)    r_timer <= 32'd0;
            else if (w_open) r_timer <= r_timer + 32'd1;
            if (w_accept && (r_state != S_CHECK)) r_chk <= r_chk ^ rx_data;
            if (w_accept && (r_state == S_LEN_HI)) r_len[15:8] <= rx_data;
            if (w_accept && (r_state == S_LEN_LO)) r_len[7:0]  <= rx_data;
            if (w_accept && (r_state == S_DATA)) begin
               r_byte_cnt <= r_byte_cnt + 2'd1;
               r_shift    <= {r_shift[15:0], rx_data};
            end
            if (w_word_done) begin
               r_wr_data      <= {r_shift, rx_data};
               r_wr_addr      <= BASE_ADDR + {14'd0, r_words_loaded, 2'b00};
               r_words_loaded <= r_words_loaded + 16'd1;
            end
            if (w_set_done) r_load_done <= 1'b1;
            if (w_set_err) begin
               r_load_error <= 1'b1;
               r_err_code   <= w_err_val;
            end
         end
      end
   end

   assign wr_en        = r_wr_en;
   assign wr_addr      = r_wr_addr;
   assign wr_data      = r_wr_data;
   assign cpu_hold     = r_cpu_hold;
   assign load_done    = r_load_done;
   assign load_error   = r_load_error;
   assign err_code     = r_err_code;
   assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_mem_loader                                                         |
// | Randomized and directed frames checked against a byte-queue image model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_mem_loader;

   localparam int unsigned ROM  = 256;
   localparam int unsigned TO   = 16;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
   logic        cpu_hold, load_done, load_error;
   logic [1:0]  err_code;
   logic [15:0] words_loaded;

   inst_mem_loader #(.ROM_SIZE(ROM), .TIMEOUT_CYCLES(TO), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .load_start(load_start), .rx_valid(rx_valid),
      .rx_data(rx_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
      .err_code(err_code), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_wr  = 0;
   logic [7:0] frame_q[$];

   always @(negedge clk) if (wr_en === 1'b1) n_wr++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic build(input int n, input bit good_chk);
      logic [7:0] x;
      frame_q.delete();
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      if (n == 0 || n > int'(ROM)) return;
      for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
      x = 8'd0;
      foreach (frame_q[i]) x ^= frame_q[i];
      frame_q.push_back(good_chk ? x : (x ^ 8'($urandom_range(255, 1))));
   endtask

   // Image model: length rule, word packing and XOR taken straight from frame_q.
   task automatic run_frame(input int gap_max, input string nm, input bit with_start);
      int n, nwr0, last, widx;
      bit bad;
      logic [7:0] x;
      logic [31:0] w;
      nwr0 = n_wr;
      if (with_start) pulse_start();
      n    = {16'd0, frame_q[0], frame_q[1]};
      bad  = (n == 0) || (n > int'(ROM));
      last = bad ? 1 : frame_q.size() - 1;
      for (int i = 0; i <= last; i++) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         send(frame_q[i]);
         if (!bad && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
            widx = (i - 2) / 4;
            w = {frame_q[i-3], frame_q[i-2], frame_q[i-1], frame_q[i]};
            check({nm, ":wr_en"},   {31'd0, wr_en}, 32'd1);
            check({nm, ":wr_addr"}, wr_addr, BASE + 32'(4 * widx));
            check({nm, ":wr_data"}, wr_data, w);
            check({nm, ":words"},   {16'd0, words_loaded}, 32'(widx + 1));
         end
      end
      x = 8'd0;
      for (int i = 0; i < 2 + 4 * n && !bad; i++) x ^= frame_q[i];
      if (bad) begin
         check({nm, ":err"},  {31'd0, load_error}, 32'd1);
         check({nm, ":code"}, {30'd0, err_code}, 32'd1);
         check({nm, ":hold"}, {31'd0, cpu_hold}, 32'd1);
      end else if (x == frame_q[last]) begin
         check({nm, ":done"}, {31'd0, load_done}, 32'd1);
         check({nm, ":err"},  {31'd0, load_error}, 32'd0);
         check({nm, ":hold"}, {31'd0, cpu_hold}, 32'd0);
         check({nm, ":words"}, {16'd0, words_loaded}, 32'(n));
      end else begin
         check({nm, ":done"}, {31'd0, load_done}, 32'd0);
         check({nm, ":code"}, {30'd0, err_code}, 32'd2);
         check({nm, ":hold"}, {31'd0, cpu_hold}, 32'd1);
      end
      tick();
      check({nm, ":nwr"}, 32'(n_wr - nwr0), bad ? 32'd0 : 32'(n));
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, ":wr_en"},   {31'd0, wr_en}, 32'd0);
      check({nm, ":wr_addr"}, wr_addr, BASE);
      check({nm, ":wr_data"}, wr_data, 32'd0);
      check({nm, ":hold"},    {31'd0, cpu_hold}, 32'd0);
      check({nm, ":done"},    {31'd0, load_done}, 32'd0);
      check({nm, ":err"},     {31'd0, load_error}, 32'd0);
      check({nm, ":code"},    {30'd0, err_code}, 32'd0);
      check({nm, ":words"},   {16'd0, words_loaded}, 32'd0);
   endtask

   initial begin
      int nwr0;
      repeat (3) tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();

      frame_q = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h3C, 8'h08, 8'h40, 8'h00, 8'h7D};
      run_frame(0, "normal", 1'b1);
      frame_q[10] = 8'h00;
      run_frame(2, "badchk", 1'b1);
      frame_q = '{8'h00, 8'h00};
      run_frame(1, "len0", 1'b1);
      frame_q = '{8'h01, 8'h01};
      run_frame(1, "len257", 1'b1);

      // Timeout: error exactly 16 edges after the last accepted byte.
      pulse_start();
      send(8'h00); send(8'h01); send(8'h0A);
      repeat (TO - 1) tick();
      check("tmo:early", {31'd0, load_error}, 32'd0);
      tick();
      check("tmo:err",  {31'd0, load_error}, 32'd1);
      check("tmo:code", {30'd0, err_code}, 32'd3);
      check("tmo:hold", {31'd0, cpu_hold}, 32'd1);

      // Abort colliding with a byte: byte dropped, frame restarts cleanly.
      nwr0 = n_wr;
      pulse_start();
      send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
      load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
      tick();
      load_start = 1'b0; rx_valid = 1'b0;
      check("abort:nwr",   32'(n_wr - nwr0), 32'd0);
      check("abort:words", {16'd0, words_loaded}, 32'd0);
      check("abort:hold",  {31'd0, cpu_hold}, 32'd1);
      frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      run_frame(0, "after_abort", 1'b0);

      // Reset coinciding with the 4th data byte.
      nwr0 = n_wr;
      pulse_start();
      send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
      reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h44;
      tick();
      reset = 1'b0; rx_valid = 1'b0;
      check_reset_vals("midrst");
      tick();
      check("midrst:nwr", 32'(n_wr - nwr0), 32'd0);
      build(1, 1'b1);
      run_frame(1, "post_rst", 1'b1);

      build(int'(ROM), 1'b1);
      run_frame(0, "full_rom", 1'b1);

      for (int k = 0; k < 24; k++) begin
         int kind;
         kind = int'($urandom_range(9, 0));
         if (kind == 0)
            build(($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(65535, ROM + 1)), 1'b1);
         else
            build(int'($urandom_range(6, 1)), kind > 2);
         run_frame(3, $sformatf("rnd%0d", k), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
# inst_mem_loader

Boot-time writer for the CPU's instruction memory. It takes a byte stream from the UART receiver, frames it as a length-prefixed, checksummed program image, and assembles big-endian 32-bit words. Each word is written into the writable instruction RAM through a single-cycle write port. While a load is in progress it holds the CPU in reset, and it releases the CPU only after the image is accepted.

## Interface
Parameters:
- ROM_SIZE, 256, capacity of the instruction memory in words; larger images are rejected.
- TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes while a frame is open.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; opens a new frame and aborts any frame in progress.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received byte.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  32  byte address, word-aligned: BASE_ADDR + 4*word_index.
- wr_data  out  32  assembled word, first byte received lands in [31:24].
- cpu_hold  out  1  keeps CPU in reset while high.
- load_done  out  1  sticky: image accepted.
- load_error  out  1  sticky: image rejected.
- err_code  out  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout.
- words_loaded  out  16  number of words written in the current frame.

## Operation
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4*N data bytes, then one CHK byte.
- CHK must equal the XOR of every byte from LEN_HI through the last data byte.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- IDLE, DONE, ERROR: load_start -> LEN_HI. This clears load_done, load_error, err_code, words_loaded, the checksum and the byte counter. rx_valid is ignored in these states.
- LEN_HI: accepts a byte -> LEN_LO.
- LEN_LO: accepts a byte, then checks N. If N==0 or N>ROM_SIZE -> ERROR with err_code=1. Otherwise -> DATA.
- DATA: accepts bytes, counting 0..3 and shifting each byte in. On the 4th byte, the next cycle asserts wr_en with wr_addr/wr_data for the current word_index, and words_loaded increments. After the Nth word -> CHECK.
- CHECK: accepts a byte. If it matches the XOR -> DONE. Otherwise -> ERROR with err_code=2. No writes occur in this state.
- Timeout: in LEN_HI through CHECK, a counter resets on each accepted byte and on entering LEN_HI. When it reaches TIMEOUT_CYCLES -> ERROR with err_code=3.
- cpu_hold is 1 in LEN_HI, LEN_LO, DATA, CHECK and ERROR, and 0 in IDLE and DONE.
- Words already written before an error or abort stay in memory; the loader does not roll them back.
- load_start in any state other than IDLE/DONE/ERROR restarts the frame at LEN_HI. Any partially assembled word is discarded and no wr_en is issued for it.
- load_start and rx_valid in the same cycle: load_start wins and the byte is dropped.

## Timing
- Reset values: state=IDLE, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=0, load_done=0, load_error=0, err_code=0, words_loaded=0.
- All outputs are registered.
- wr_en rises exactly 1 cycle after the cycle in which the 4th byte of a word was accepted. It lasts 1 cycle, and wr_addr/wr_data are stable during it.
- load_done/load_error and the matching cpu_hold value take effect 1 cycle after the deciding byte or timeout.
- Back-to-back rx_valid on every cycle is supported with no byte loss. This includes a wr_en cycle coinciding with the next word's first byte.
- Address arithmetic: wr_addr = BASE_ADDR + {word_index, 2'b00}, modulo 2^32. word_index never exceeds ROM_SIZE-1.
- Reset asserted mid-frame returns to IDLE on the next edge, drops cpu_hold, and suppresses any pending wr_en.

## Test plan
- Normal load: send start, then 00 02 08 00 00 03 3C 08 40 00 CHK=0x7D. Expect wr_en at addr 0x0 with 0x08000003, wr_en at addr 0x4 with 0x3C084000, then load_done=1, cpu_hold=0 and words_loaded=2.
- Bad length: send start, then 00 00 -> load_error=1, err_code=1, no wr_en. Repeat with start, then 01 01 (N=257) -> same result.
- Checksum error: the normal-load frame with CHK=0x00 -> both words are written, then load_error=1, err_code=2, cpu_hold stays 1.
- Timeout: send start, 00 01 0A, then silence for TIMEOUT_CYCLES (set to 16 in the bench). Expect err_code=3 at cycle 16 after the last byte.
- Abort and collision: send start, 00 01 AA BB, then load_start together with rx_valid=CC. Expect no wr_en, state LEN_HI, and CC dropped. A following clean 1-word frame loads correctly at address 0x0.
- Reset mid-DATA after the 4th byte, in the same cycle: expect no wr_en, all outputs at their reset values, and the next start loads normally.
